// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encoding, terminal-mode encoding
// and a constant function for sizing counters and prescalers.
package counter_pkg;

    // Count direction as seen on the dir input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Terminal behaviour selector for the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold the values 0..value-1, never less than one bit.
    function automatic int clog2(input int unsigned value);
        int bits;
        bits = 1;
        while ((64'd1 << bits) < {32'd0, value}) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/tick_counter_if.sv
// Control/status bundle of the tick counter. The controlling side uses the
// master modport; the counter itself uses the slave modport.
interface tick_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;

    modport master (
        output en, dir, clear, load, load_val,
        input  count, tick, tc
    );

    modport slave (
        input  en, dir, clear, load, load_val,
        output count, tick, tc
    );
endinterface

// File: rtl/tick_gen.sv
// Integer prescaler producing a one-cycle registered tick every DIV enabled
// cycles. tick_next is the same pulse one cycle early, so a client can
// update its own registers on the edge where tick rises.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int            PW   = clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("tick_gen: DIV must be at least 1");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    // Next prescaler value and tick: clear restarts the period, en=0 freezes it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else if (en) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick      = tick_q;
    assign tick_next = tick_d;

endmodule

// File: rtl/tick_counter.sv
// Prescaled up/down counter with wrap or saturate terminal behaviour,
// synchronous clear and parallel load. Defining TICK_COUNTER_STEP_EN adds
// a step_btn pushbutton input that steps the counter once per press.
module tick_counter
    import counter_pkg::*;
#(
    parameter int unsigned     CLK_HZ    = 16_000_000,
    parameter int unsigned     TICK_HZ   = 1,
    parameter int              WIDTH     = 4,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE  = MODE_WRAP
) (
    input  logic CLK,
    input  logic RST_N,
`ifdef TICK_COUNTER_STEP_EN
    input  logic step_btn,
`endif
    tick_counter_if.slave bus
);

    localparam int unsigned      TICK_DIV = (TICK_HZ == 0) ? 1 : TICK_HZ;
    localparam int unsigned      DIV      = CLK_HZ / TICK_DIV;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);

    if (TICK_HZ == 0 || (CLK_HZ % TICK_DIV) != 0 || DIV < 1) begin : g_bad_div
        $error("tick_counter: CLK_HZ/TICK_HZ must be an integer >= 1");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("tick_counter: WIDTH must be 1..32");
    end
    if (MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("tick_counter: MAX_COUNT does not fit in WIDTH bits");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $error("tick_counter: SATURATE must be 0 or 1");
    end

    logic             tick_w;
    logic             step_tick;
    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (bus.en),
        .clear     (bus.clear),
        .tick      (tick_w),
        .tick_next (step_tick)
    );

`ifdef TICK_COUNTER_STEP_EN
    logic btn_meta_q, btn_sync_q, btn_prev_q;
    logic btn_rise;

    // Two-flop synchroniser for the pushbutton plus the previous-value flop
    // for rising-edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= step_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign btn_rise = btn_sync_q & ~btn_prev_q;
    // A press coinciding with a tick still yields a single step.
    assign step     = step_tick | btn_rise;
`else
    assign step     = step_tick;
`endif

    // Next count and terminal pulse, priority clear > load > step.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (step) begin
            if (bus.dir == DIR_UP) begin
                if (count_q == MAX_V) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE == MODE_SAT) ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE == MODE_SAT) ? count_q : MAX_V;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_w;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter with DIV=4 and WIDTH=4. Three instances
// share one stimulus: A (MAX_COUNT=15, wrap), B (MAX_COUNT=9, wrap) and
// C (MAX_COUNT=9, saturate). Outputs are sampled on the falling edge; "N<k>"
// in tags means the falling edge after the k-th rising edge since reset release.
module tb_tick_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
`ifdef TICK_COUNTER_STEP_EN
    logic       step_btn;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    tick_counter_if #(.WIDTH(4)) if_a ();
    tick_counter_if #(.WIDTH(4)) if_b ();
    tick_counter_if #(.WIDTH(4)) if_c ();

    assign if_a.en = en;  assign if_a.dir = dir;  assign if_a.clear = clear;
    assign if_a.load = load;  assign if_a.load_val = load_val;
    assign if_b.en = en;  assign if_b.dir = dir;  assign if_b.clear = clear;
    assign if_b.load = load;  assign if_b.load_val = load_val;
    assign if_c.en = en;  assign if_c.dir = dir;  assign if_c.clear = clear;
    assign if_c.load = load;  assign if_c.load_val = load_val;

    tick_counter #(
        .CLK_HZ(8), .TICK_HZ(2), .WIDTH(4), .MAX_COUNT(15), .SATURATE(0)
    ) u_a (
        .CLK      (clk),
        .RST_N    (rst_n),
`ifdef TICK_COUNTER_STEP_EN
        .step_btn (step_btn),
`endif
        .bus      (if_a)
    );

    tick_counter #(
        .CLK_HZ(8), .TICK_HZ(2), .WIDTH(4), .MAX_COUNT(9), .SATURATE(0)
    ) u_b (
        .CLK      (clk),
        .RST_N    (rst_n),
`ifdef TICK_COUNTER_STEP_EN
        .step_btn (step_btn),
`endif
        .bus      (if_b)
    );

    tick_counter #(
        .CLK_HZ(8), .TICK_HZ(2), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1)
    ) u_c (
        .CLK      (clk),
        .RST_N    (rst_n),
`ifdef TICK_COUNTER_STEP_EN
        .step_btn (step_btn),
`endif
        .bus      (if_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        en       = 1'b0;
        dir      = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
`ifdef TICK_COUNTER_STEP_EN
        step_btn = 1'b0;
`endif
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;

        // Held in reset across a few edges.
        wait_neg(2);
        check("rst_count", 32'(if_a.count), 32'd0);
        check("rst_tick",  32'(if_a.tick),  32'd0);
        check("rst_tc",    32'(if_a.tc),    32'd0);

        // N0: release, count up.
        rst_n = 1'b1;
        en    = 1'b1;
        dir   = 1'b1;
        wait_neg(3);  // N3
        check("N3_tick",  32'(if_a.tick),  32'd0);
        check("N3_count", 32'(if_a.count), 32'd0);
        wait_neg(1);  // N4
        check("N4_tick",  32'(if_a.tick),  32'd1);
        check("N4_count", 32'(if_a.count), 32'd1);
        check("N4_tc",    32'(if_a.tc),    32'd0);
        wait_neg(1);  // N5
        check("N5_tick",  32'(if_a.tick),  32'd0);
        wait_neg(3);  // N8
        check("N8_tick",  32'(if_a.tick),  32'd1);
        check("N8_count", 32'(if_a.count), 32'd2);
        wait_neg(4);  // N12
        check("N12_tick",  32'(if_a.tick),  32'd1);
        check("N12_count", 32'(if_a.count), 32'd3);
        check("N12_tc",    32'(if_a.tc),    32'd0);

        // Load 8, then wrap at MAX_COUNT=9 in B.
        load     = 1'b1;
        load_val = 4'd8;
        wait_neg(1);  // N13
        load = 1'b0;
        check("N13_b_load", 32'(if_b.count), 32'd8);
        wait_neg(3);  // N16
        check("N16_b_count", 32'(if_b.count), 32'd9);
        check("N16_b_tc",    32'(if_b.tc),    32'd0);
        wait_neg(4);  // N20
        check("N20_b_wrap",  32'(if_b.count), 32'd0);
        check("N20_b_tc",    32'(if_b.tc),    32'd1);
        check("N20_c_hold",  32'(if_c.count), 32'd9);
        check("N20_c_tc",    32'(if_c.tc),    32'd1);
        check("N20_a_count", 32'(if_a.count), 32'd10);
        check("N20_a_tc",    32'(if_a.tc),    32'd0);

        // Down from 0 wraps to MAX_COUNT.
        dir = 1'b0;
        wait_neg(1);  // N21
        check("N21_b_tc_drop", 32'(if_b.tc), 32'd0);
        wait_neg(3);  // N24
        check("N24_b_down_wrap", 32'(if_b.count), 32'd9);
        check("N24_b_tc",        32'(if_b.tc),    32'd1);
        check("N24_c_down",      32'(if_c.count), 32'd8);
        check("N24_c_tc",        32'(if_c.tc),    32'd0);
        check("N24_a_down",      32'(if_a.count), 32'd9);

        // Saturation in C: reach 9, then three blocked steps.
        dir = 1'b1;
        wait_neg(4);  // N28
        check("N28_c_count", 32'(if_c.count), 32'd9);
        check("N28_c_tc",    32'(if_c.tc),    32'd0);
        check("N28_b_wrap",  32'(if_b.count), 32'd0);
        wait_neg(4);  // N32
        check("N32_c_sat",  32'(if_c.count), 32'd9);
        check("N32_c_tc",   32'(if_c.tc),    32'd1);
        check("N32_c_tick", 32'(if_c.tick),  32'd1);
        wait_neg(1);  // N33
        check("N33_c_tc", 32'(if_c.tc), 32'd0);
        wait_neg(3);  // N36
        check("N36_c_sat", 32'(if_c.count), 32'd9);
        check("N36_c_tc",  32'(if_c.tc),    32'd1);
        wait_neg(4);  // N40
        check("N40_c_sat", 32'(if_c.count), 32'd9);
        check("N40_c_tc",  32'(if_c.tc),    32'd1);
        check("N40_a_count", 32'(if_a.count), 32'd13);

        // Clear and load together on a tick edge: clear wins.
        wait_neg(3);  // N43
        clear    = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        wait_neg(1);  // N44
        clear = 1'b0;
        load  = 1'b0;
        check("N44_clr_count", 32'(if_a.count), 32'd0);
        check("N44_clr_tick",  32'(if_a.tick),  32'd0);
        check("N44_clr_tc",    32'(if_a.tc),    32'd0);
        check("N44_clr_c",     32'(if_c.count), 32'd0);
        wait_neg(3);  // N47
        check("N47_tick", 32'(if_a.tick), 32'd0);
        wait_neg(1);  // N48
        check("N48_tick",  32'(if_a.tick),  32'd1);
        check("N48_count", 32'(if_a.count), 32'd1);

        // Load above MAX_COUNT clamps.
        load     = 1'b1;
        load_val = 4'd15;
        wait_neg(1);  // N49
        load = 1'b0;
        check("N49_b_clamp", 32'(if_b.count), 32'd9);
        check("N49_a_load",  32'(if_a.count), 32'd15);
        wait_neg(1);  // N50
        en = 1'b0;
        wait_neg(1);  // N51
        check("N51_frozen_tick", 32'(if_a.tick), 32'd0);
        wait_neg(9);  // N60
        check("N60_frozen_b", 32'(if_b.count), 32'd9);
        check("N60_frozen_a", 32'(if_a.count), 32'd15);
        check("N60_tick",     32'(if_a.tick),  32'd0);

        // Prescaler held at 2, so two more enabled cycles to the tick.
        en = 1'b1;
        wait_neg(1);  // N61
        check("N61_tick", 32'(if_a.tick), 32'd0);
        wait_neg(1);  // N62
        check("N62_tick",   32'(if_a.tick),  32'd1);
        check("N62_b_wrap", 32'(if_b.count), 32'd0);
        check("N62_b_tc",   32'(if_b.tc),    32'd1);
        check("N62_a_wrap", 32'(if_a.count), 32'd0);
        check("N62_a_tc",   32'(if_a.tc),    32'd1);
        check("N62_c_sat",  32'(if_c.count), 32'd9);
        check("N62_c_tc",   32'(if_c.tc),    32'd1);

        // Asynchronous reset mid-period with count=7.
        load     = 1'b1;
        load_val = 4'd7;
        wait_neg(1);  // N63
        load = 1'b0;
        check("N63_load7", 32'(if_a.count), 32'd7);
        wait_neg(1);  // N64
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(if_a.count), 32'd0);
        check("async_rst_tick",  32'(if_a.tick),  32'd0);
        @(negedge clk);  // new N0
        rst_n = 1'b1;
        wait_neg(3);
        check("rel_N3_tick", 32'(if_a.tick), 32'd0);
        wait_neg(1);
        check("rel_N4_tick",  32'(if_a.tick),  32'd1);
        check("rel_N4_count", 32'(if_a.count), 32'd1);

`ifdef TICK_COUNTER_STEP_EN
        // Button steps with en=0: three cycles from press to count change.
        en    = 1'b0;
        clear = 1'b1;
        wait_neg(1);
        clear    = 1'b0;
        step_btn = 1'b1;
        wait_neg(2);
        check("btn_2cyc_count", 32'(if_a.count), 32'd0);
        wait_neg(1);
        check("btn_3cyc_count", 32'(if_a.count), 32'd1);
        check("btn_tc",         32'(if_a.tc),    32'd0);
        step_btn = 1'b0;
        wait_neg(3);
        check("btn_single", 32'(if_a.count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Parametrised successor to the fixed 4-bit, 1 Hz LED counter.
- A single-clock-domain block containing:
  - an integer prescaler that produces a one-cycle tick enable, replacing the derived divided clock;
  - an up/down counter with programmable width, terminal value, wrap or saturate mode, synchronous clear and parallel load.
- Sits between the board clock (16 MHz) and the LED/pin outputs in top.

Parameters:
- CLK_HZ, 16_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count-step rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer ≥1; elaboration error otherwise.
- WIDTH, 4, count width in bits (1..32).
- MAX_COUNT, 2**WIDTH-1, terminal (largest) count value. Must be ≤ 2**WIDTH-1.
- SATURATE, 0, terminal behaviour:
  - 0: wrap.
  - 1: hold at limit.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- en  in  1  enables prescaler and counting. When low, both freeze.
- dir  in  1  count direction: 1 = up, 0 = down.
- clear  in  1  synchronous clear of prescaler and count.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tick  out  1  one-cycle prescaler pulse, registered.
- tc  out  1  one-cycle terminal-count pulse, registered.

Behaviour:
- Reset:
  - RST_N low asynchronously forces prescaler=0, count=0, tick=0, tc=0.
  - Release is sampled on the next CLK rising edge.
- Prescaler:
  - Counts 0..DIV-1 while en=1.
  - tick=1 for exactly the cycle following the edge where the prescaler equalled DIV-1; the prescaler wraps to 0 on that same edge.
  - Period is exactly DIV cycles. The old divider's off-by-one (N+1 cycles per half-period) is corrected.
  - DIV=1: tick stays high continuously while en=1.
  - en=0: prescaler holds its value; tick=0 from the next cycle.
- Step:
  - Occurs on the edge where en=1, the prescaler is at DIV-1, and neither clear nor load is asserted.
  - The new count is visible one cycle later, concurrent with tick=1.
- Priority on each edge: clear > load > step.
  - clear: prescaler←0, count←0, tc←0. Applies regardless of en.
  - load: count←min(load_val, MAX_COUNT). Prescaler is unaffected and keeps running. Applies regardless of en. No tc is generated.
- Up step (dir=1):
  - count<MAX_COUNT: count+1.
  - At MAX_COUNT, wrap mode: count←0, tc=1.
  - At MAX_COUNT, saturate mode: count holds, tc=1.
- Down step (dir=0):
  - count>0: count-1.
  - At 0, wrap mode: count←MAX_COUNT, tc=1.
  - At 0, saturate mode: count holds, tc=1.
- tc rules:
  - High exactly one cycle, aligned with tick.
  - Otherwise 0.
  - Repeats on every blocked step while saturated.
- dir changes take effect at the next step. No glitch and no extra step.
- All arithmetic is unsigned WIDTH bits. Comparison is against MAX_COUNT, not 2**WIDTH-1.
- Reset mid-period: prescaler restarts, so the first tick after release occurs DIV cycles later.

Optional Feature:
- Macro: TICK_COUNTER_STEP_EN
- Defined:
  - Adds port step_btn (in, 1, asynchronous pushbutton).
  - Input passes through a 2-flop synchroniser to a rising-edge detector. Each detected edge performs one step in the current direction, independent of en and the prescaler. tc rules are identical.
  - If a button step and a tick step coincide, only one step is taken.
  - Priority: clear > load > (tick step OR button step).
  - Latency: 3 cycles from step_btn rising to count change.
  - Synchroniser flops reset to 0.
- Undefined: no port; behaviour exactly as above.

Decomposition:
- Shared package counter_pkg:
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - terminal mode constants MODE_WRAP=0, MODE_SAT=1;
  - clog2 helper function for sizing the prescaler.
- Sub-module tick_gen:
  - Parameters DIV.
  - Ports CLK, RST_N, en, clear, tick.
  - Reused by other blocks needing slow enables.
- Counter/terminal logic stays in tick_counter.

Test Plan (CLK_HZ=8, TICK_HZ=2 → DIV=4; WIDTH=4 unless noted):
- Reset release, en=1, dir=1: tick pulses at cycles 4, 8, 12 after release; count reads 1, 2, 3 at those cycles; tc stays 0.
- MAX_COUNT=9, SATURATE=0, up from load_val=8: count 8→9→0; tc=1 only in the cycle count becomes 0. Then dir=0: count 0→9 with tc=1.
- SATURATE=1, MAX_COUNT=9, count=9, dir=1 for 3 ticks: count stays 9; tc pulses 3 times aligned with tick.
- Simultaneous clear and load=1 (load_val=5) on a tick edge: count=0, prescaler=0, tc=0. Next tick comes 4 cycles later.
- load_val=15 with MAX_COUNT=9: count=9. Then en=0 for 10 cycles: count and prescaler frozen, tick=0. Re-enable: the tick arrives after the remaining prescaler cycles.
- RST_N pulsed low mid-period with count=7: count=0 and tick=0 immediately (asynchronously). With TICK_COUNTER_STEP_EN defined and en=0, a step_btn edge raises count to 1 after 3 cycles.
